// File: rtl/furv_pkg.sv
// Shared furv bus definitions: bus word width, GPIO register offsets and the
// default LED GPIO base address.
package furv_pkg;

    localparam int unsigned BUS_WORD = 32;

    // Byte offsets inside a 32-byte GPIO register window.
    localparam logic [4:0] GPIO_OUT     = 5'h00;
    localparam logic [4:0] GPIO_SET     = 5'h04;
    localparam logic [4:0] GPIO_CLR     = 5'h08;
    localparam logic [4:0] GPIO_TGL     = 5'h0C;
    localparam logic [4:0] GPIO_IN      = 5'h10;
    localparam logic [4:0] GPIO_STATUS  = 5'h14;
    localparam logic [4:0] GPIO_RISE_EN = 5'h18;
    localparam logic [4:0] GPIO_FALL_EN = 5'h1C;

    localparam logic [31:0] LED_GPIO_BASE = 32'h0000_0400;

endpackage : furv_pkg

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser for a pin vector, plus one extra delayed
// stage so the consumer can detect edges on the synchronised value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all stages)
//   d          : asynchronous pin inputs
//   sync_q     : last synchroniser stage
//   prev_q     : sync_q delayed by one cycle
module gpio_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] prev_q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain: stage 0 captures the pins, prev_q trails the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign sync_q = stage_q[STAGES-1];

endmodule : gpio_sync

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO block on the furv data bus: output latch with
// set/clear/toggle aliases, synchronised inputs, sticky edge flags (W1C) and
// a level interrupt.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   addr, data_in     : byte address and write data from the core
//   mem_en, mem_read  : access strobe and direction (1 = read)
//   data_out, sel     : registered read data and its valid flag
//   gpio_out, gpio_in : pin drive and asynchronous pin inputs
//   irq               : registered OR of the edge status flags
module mmio_gpio
    import furv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = LED_GPIO_BASE,
    parameter int unsigned WIDTH       = 6,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BUS_WORD-1:0] addr,
    input  logic [BUS_WORD-1:0] data_in,
    output logic [BUS_WORD-1:0] data_out,
    input  logic                mem_en,
    input  logic                mem_read,
    output logic                sel,
    output logic [WIDTH-1:0]    gpio_out,
    input  logic [WIDTH-1:0]    gpio_in,
    output logic                irq
);

    logic [WIDTH-1:0] out_q, status_q, rise_en_q, fall_en_q;
    logic [WIDTH-1:0] out_d, status_d, rise_en_d, fall_en_d;
    logic [WIDTH-1:0] sync_q, prev_q;
    logic [WIDTH-1:0] wd_c, rise_c, fall_c, w1c_c;
    logic [WIDTH-1:0] rd_data_c;
    logic             hit_c, wr_c, rd_c;
    logic [2:0]       idx_c;
    logic             unused_bits;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (gpio_in),
        .sync_q (sync_q),
        .prev_q (prev_q)
    );

    // Address decode: 32-byte window, word index in addr[4:2].
    assign hit_c = mem_en && (addr[31:5] == BASE_ADDR[31:5]);
    assign wr_c  = hit_c && !mem_read;
    assign rd_c  = hit_c && mem_read;
    assign idx_c = addr[4:2];
    assign wd_c  = data_in[WIDTH-1:0];

    assign rise_c = sync_q & ~prev_q & rise_en_q;
    assign fall_c = ~sync_q & prev_q & fall_en_q;

    // Register write path; edge sets override a same-cycle W1C.
    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_c     = '0;
        if (wr_c) begin
            case (idx_c)
                GPIO_OUT[4:2]:     out_d     = wd_c;
                GPIO_SET[4:2]:     out_d     = out_q | wd_c;
                GPIO_CLR[4:2]:     out_d     = out_q & ~wd_c;
                GPIO_TGL[4:2]:     out_d     = out_q ^ wd_c;
                GPIO_STATUS[4:2]:  w1c_c     = wd_c;
                GPIO_RISE_EN[4:2]: rise_en_d = wd_c;
                GPIO_FALL_EN[4:2]: fall_en_d = wd_c;
                default:           out_d     = out_q;
            endcase
        end
        status_d = (status_q & ~w1c_c) | rise_c | fall_c;
    end

    // Read mux; write-only aliases read as zero.
    always_comb begin
        rd_data_c = '0;
        case (idx_c)
            GPIO_OUT[4:2]:     rd_data_c = out_q;
            GPIO_IN[4:2]:      rd_data_c = sync_q;
            GPIO_STATUS[4:2]:  rd_data_c = status_q;
            GPIO_RISE_EN[4:2]: rd_data_c = rise_en_q;
            GPIO_FALL_EN[4:2]: rd_data_c = fall_en_q;
            default:           rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= RESET_VALUE[WIDTH-1:0];
            status_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq       <= 1'b0;
            sel       <= 1'b0;
            data_out  <= '0;
        end else begin
            out_q     <= out_d;
            status_q  <= status_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq       <= |status_q;
            sel       <= rd_c;
            if (rd_c) begin
                data_out <= BUS_WORD'(rd_data_c);
            end
        end
    end

    assign gpio_out = out_q ^ {WIDTH{ACTIVE_LOW}};

    // Byte lane bits and upper data bits are architecturally ignored.
    assign unused_bits = ^{addr[1:0], data_in};

endmodule : mmio_gpio

// File: tb/tb_mmio_gpio.sv
// Randomised self-checking bench for mmio_gpio against a register-level
// reference model, with directed sequences for the interesting corners.
module tb_mmio_gpio;

    localparam int unsigned W    = 6;
    localparam int unsigned SYNC = 2;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [W-1:0] MASK = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, data_in, data_out;
    logic        mem_en, mem_read, sel, irq;
    logic [W-1:0] gpio_out, gpio_in;

    int checks = 0;
    int failures = 0;

    // Reference model state (logical register contents).
    logic [W-1:0] m_out, m_status, m_ren, m_fen;
    logic         m_irq, m_sel;
    logic [31:0]  m_dout;
    logic [W-1:0] pin_hist [SYNC+1];  // pin_hist[k]: pin sampled k+1 edges ago

    always #5 clk = ~clk;

    mmio_gpio #(
        .BASE_ADDR   (BASE),
        .WIDTH       (W),
        .ACTIVE_LOW  (1'b1),
        .RESET_VALUE (32'h0),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .mem_en   (mem_en),
        .mem_read (mem_read),
        .sel      (sel),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_status = '0; m_ren = '0; m_fen = '0;
        m_irq = 1'b0; m_sel = 1'b0; m_dout = '0;
        for (int i = 0; i <= SYNC; i++) pin_hist[i] = '0;
    endtask

    // Advance one clock: model computes the post-edge state from current
    // inputs, then all visible outputs are compared shortly after the edge.
    task automatic tick();
        logic [W-1:0] in_now, in_old, rise, fall, w1c, wd;
        logic         hit;
        logic [4:0]   off;
        in_now = pin_hist[SYNC-1];
        in_old = pin_hist[SYNC];
        rise = in_now & ~in_old & m_ren;
        fall = ~in_now & in_old & m_fen;
        hit  = mem_en && (addr[31:5] == BASE[31:5]);
        off  = {addr[4:2], 2'b00};
        wd   = data_in[W-1:0];
        w1c  = '0;
        m_sel = hit && mem_read;
        if (hit && mem_read) begin
            case (off)
                5'h00:   m_dout = 32'(m_out);
                5'h10:   m_dout = 32'(in_now);
                5'h14:   m_dout = 32'(m_status);
                5'h18:   m_dout = 32'(m_ren);
                5'h1C:   m_dout = 32'(m_fen);
                default: m_dout = 32'h0;
            endcase
        end
        m_irq = (m_status != '0);
        if (hit && !mem_read) begin
            case (off)
                5'h00: m_out = wd;
                5'h04: m_out = m_out | wd;
                5'h08: m_out = m_out & ~wd;
                5'h0C: m_out = m_out ^ wd;
                5'h14: w1c = wd;
                5'h18: m_ren = wd;
                5'h1C: m_fen = wd;
                default: ;
            endcase
        end
        m_status = (m_status & ~w1c) | rise | fall;
        for (int i = SYNC; i > 0; i--) pin_hist[i] = pin_hist[i-1];
        pin_hist[0] = gpio_in;
        @(posedge clk);
        #1;
        check_eq("gpio_out", 32'(gpio_out), 32'(m_out ^ MASK));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("sel", 32'(sel), 32'(m_sel));
        check_eq("data_out", data_out, m_dout);
    endtask

    task automatic bus(input logic en, input logic rd, input logic [31:0] a, input logic [31:0] d);
        mem_en = en; mem_read = rd; addr = a; data_in = d;
        tick();
        mem_en = 1'b0; mem_read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        bus(1'b1, 1'b1, a, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, $urandom, $urandom);
    endtask

    initial begin
        rst_n = 1'b0; mem_en = 1'b0; mem_read = 1'b0;
        addr = '0; data_in = '0; gpio_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_gpio_out", 32'(gpio_out), 32'h3F);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_sel", 32'(sel), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset-state read of OUT.
        rd(BASE);
        check_eq("rd_out_reset", data_out, 32'h0);

        // Latch aliases.
        wr(BASE + 32'h00, 32'h15); check_eq("out_wr", 32'(gpio_out), 32'h2A);
        wr(BASE + 32'h04, 32'h22); check_eq("out_set", 32'(gpio_out), 32'h08);
        wr(BASE + 32'h08, 32'h01); check_eq("out_clr", 32'(gpio_out), 32'h09);
        wr(BASE + 32'h0C, 32'h3F); check_eq("out_tgl", 32'(gpio_out), 32'h36);
        rd(BASE + 32'h00); check_eq("rd_out", data_out, 32'h09);
        rd(BASE + 32'h04); check_eq("rd_set", data_out, 32'h0);

        // Edge detection and interrupt.
        wr(BASE + 32'h18, 32'h01);
        wr(BASE + 32'h1C, 32'h02);
        gpio_in = 6'h03;
        idle(2);
        rd(BASE + 32'h10); check_eq("rd_in_lat", data_out, 32'h03);
        idle(3);
        gpio_in = 6'h00;
        idle(4);
        rd(BASE + 32'h14); check_eq("status_both", data_out, 32'h03);
        check_eq("irq_set", 32'(irq), 32'h1);

        // W1C racing a new rise: hardware set wins.
        wr(BASE + 32'h14, 32'h02);
        gpio_in = 6'h01;
        idle(2);
        wr(BASE + 32'h14, 32'h01);
        rd(BASE + 32'h14); check_eq("w1c_race", data_out, 32'h01);
        wr(BASE + 32'h14, 32'h01);
        check_eq("irq_lag", 32'(irq), 32'h1);
        idle(1);
        check_eq("irq_drop", 32'(irq), 32'h0);

        // Address decode boundaries and byte-offset aliasing.
        wr(32'h0000_0420, 32'h3F); check_eq("miss_hi", 32'(gpio_out), 32'h36);
        wr(32'h0000_03FC, 32'h3F); check_eq("miss_lo", 32'(gpio_out), 32'h36);
        rd(32'h0000_0420); check_eq("miss_sel", 32'(sel), 32'h0);
        wr(32'h0000_0401, 32'h3F); check_eq("alias", 32'(gpio_out), 32'h00);

        // Async reset mid-cycle with live state.
        wr(BASE + 32'h00, 32'h2A);
        wr(BASE + 32'h18, 32'h03);
        wr(BASE + 32'h1C, 32'h03);
        gpio_in = 6'h00;
        idle(3);
        gpio_in = 6'h03;
        idle(4);
        rd(BASE + 32'h14); check_eq("pre_rst_status", data_out, 32'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_gpio_out", 32'(gpio_out), 32'h3F);
        check_eq("async_irq", 32'(irq), 32'h0);
        check_eq("async_sel", 32'(sel), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(BASE + 32'h14); check_eq("post_rst_status", data_out, 32'h0);
        rd(BASE + 32'h18); check_eq("post_rst_ren", data_out, 32'h0);
        rd(BASE + 32'h00); check_eq("post_rst_out", data_out, 32'h0);
        rd(BASE + 32'h10); check_eq("post_rst_in", data_out, 32'h03);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a;
            int sel_kind;
            sel_kind = int'($urandom_range(0, 9));
            if (sel_kind < 7)       a = BASE + 32'($urandom_range(0, 31));
            else if (sel_kind == 7) a = BASE + 32'h20 + 32'($urandom_range(0, 31));
            else if (sel_kind == 8) a = BASE - 32'($urandom_range(1, 32));
            else                    a = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
            bus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mmio_gpio

// File: doc/mmio_gpio.md
Name: mmio_gpio

Overview:
Parametrised memory-mapped GPIO peripheral on the furv data bus (addr/data_in/data_out/mem_read/mem_en). It replaces the hard-wired single LED store with a relocatable register block. The block provides:
- output latch with set/clear/toggle aliases
- synchronised inputs
- sticky edge detection with write-1-to-clear status and a level interrupt

Top instantiates one per pin group (LEDs, buttons), clocked by sysclk.

Parameters:
BASE_ADDR, 32'h0000_0400, byte base address; 32-byte aligned (bits [4:0] zero)
WIDTH, 6, number of GPIO pins, 1..32
ACTIVE_LOW, 1, 1 = gpio_out drives the inverted latch value
RESET_VALUE, 0, latch value after reset (logical, before inversion)
SYNC_STAGES, 2, input synchroniser depth, >=2

Ports:
clk  input  1  system clock (sysclk in top)
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address from core
data_in  input  32  write data from core
data_out  output  32  read data to core, registered
mem_en  input  1  bus access strobe, one cycle per access
mem_read  input  1  1 = read, 0 = write; qualified by mem_en
sel  output  1  registered: data_out is valid for the access in the previous cycle
gpio_out  output  WIDTH  pin drive
gpio_in  input  WIDTH  asynchronous pin inputs
irq  output  1  level interrupt

Behaviour:
- Hit: mem_en && addr[31:5]==BASE_ADDR[31:5]. Register index is addr[4:2]; addr[1:0] is ignored. Only bits [WIDTH-1:0] of registers exist; upper read bits are 0 and upper write bits are ignored.
- Register map (offset, access):
  - 0x00 OUT, rw
  - 0x04 SET, wo: OUT |= wd
  - 0x08 CLR, wo: OUT &= ~wd
  - 0x0C TGL, wo: OUT ^= wd
  - 0x10 IN, ro: synchronised pins
  - 0x14 STATUS, r/w1c: sticky edge flags
  - 0x18 RISE_EN, rw
  - 0x1C FALL_EN, rw
- Reads of SET/CLR/TGL return 0. Writes to IN are ignored.
- Writes take effect at the clk edge of the access. gpio_out = OUT ^ {WIDTH{ACTIVE_LOW}} is combinational from the OUT flop, so the pin changes in the same cycle OUT updates.
- Reads: data_out and sel are registered one cycle after a read hit. sel is 1 for exactly that cycle; data_out holds its value otherwise.
- A non-hit or a write leaves sel=0. Other bus slaves mux on sel.
- Synchroniser: SYNC_STAGES flops per pin. sync_q is the last stage and prev_q is one further flop.
  - IN reads sync_q, so the pin-to-IN latency is SYNC_STAGES cycles.
  - rise[i] = sync_q[i] & ~prev_q[i] & RISE_EN[i]
  - fall[i] = ~sync_q[i] & prev_q[i] & FALL_EN[i]
- STATUS update: STATUS_next = (STATUS & ~w1c_mask) | rise | fall. An edge in the same cycle as a w1c of that bit leaves the bit set (hardware set wins).
- irq = |STATUS, registered (follows the STATUS flop).
- Disabling an enable does not clear an already-set STATUS bit.
- Reset (async assert, sync release externally assumed clean):
  - OUT=RESET_VALUE, so gpio_out = RESET_VALUE ^ mask
  - STATUS=0, RISE_EN=0, FALL_EN=0
  - sync and prev flops=0, data_out=0, sel=0, irq=0
- Reset mid-access discards the access.
- The synchroniser is cleared to 0, so a pin held high at release reads IN=1 after SYNC_STAGES cycles. No edge is flagged because RISE_EN=0.

Decomposition:
- Shared package (furv_pkg): register offset constants GPIO_OUT..GPIO_FALL_EN, BUS_WORD=32, and the default GPIO base address constant LED_GPIO_BASE=32'h400.
- One sub-module: gpio_sync (per-vector SYNC_STAGES synchroniser plus prev stage, outputs sync_q/prev_q), reset by rst_n.
- The register file and edge logic stay in mmio_gpio.

Test Plan:
1. Reset with defaults -> gpio_out=6'b111111, irq=0, sel=0. Then read 0x400 -> next cycle sel=1, data_out=0.
2. Write 0x400=0x15, then SET 0x404=0x22, CLR 0x408=0x01, TGL 0x40C=0x3F -> OUT sequence 0x15, 0x37, 0x36, 0x09. gpio_out=~OUT each cycle; read OUT returns 0x09; read SET returns 0.
3. RISE_EN=0x01, FALL_EN=0x02; drive gpio_in 0->0x03, hold 5 cycles, then 0x00:
   - IN reads 0x03 after 2 cycles
   - STATUS=0x01 after the rise, then STATUS=0x03 after the fall
   - irq rises one cycle after STATUS becomes non-zero
4. STATUS=0x01; write 0x414=0x01 in the same cycle a new bit-0 rise reaches sync_q -> STATUS stays 0x01. A w1c on a quiet cycle -> STATUS=0, irq drops next cycle.
5. Write 0x420 and 0x3FC (BASE_ADDR=0x400) and 0x401 with data 0x3F -> OUT unchanged for 0x420 and 0x3FC, sel stays 0. 0x401 aliases offset 0x00 -> OUT=0x3F.
6. Assert rst_n low mid-pulse with OUT=0x2A, STATUS=0x03 -> immediately (no clk edge) gpio_out=0x3F, irq=0, STATUS=0. After release, reads return reset values.
